// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the stage-2a issue logic and the HI/LO multiply/divide unit.
// The core drives the master side; the unit presents the slave side.
interface muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              mul__active_2a;
  logic [3:0]        mul__opcode_2a;
  logic [DATA_W-1:0] rs_data_2a;
  logic [DATA_W-1:0] rt_data_2a;
  logic              mul__flush;
  logic [DATA_W-1:0] mul__rd_data_3a;
  logic              mul__stall_2a;
  logic              mul__busy;

  modport master (
    output mul__active_2a, mul__opcode_2a, rs_data_2a, rt_data_2a, mul__flush,
    input  mul__rd_data_3a, mul__stall_2a, mul__busy
  );

  modport slave (
    input  mul__active_2a, mul__opcode_2a, rs_data_2a, rt_data_2a, mul__flush,
    output mul__rd_data_3a, mul__stall_2a, mul__busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide/accumulate unit with MT*/MF* access, flush and divide-by-zero early-out.
// Latency: mul MUL_STAGES, div DATA_W+1 (1 if divisor is 0), MFHI/MFLO result registered 1 cycle.
// Backpressure: any op presented while busy is stalled combinationally; caller holds and retries.
module muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int MUL_STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_b,
  muldiv_unit_if.slave mdu
);

  localparam int PW      = 2 * DATA_W;
  localparam int CNT_MAX = (DATA_W > MUL_STAGES) ? DATA_W : MUL_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_MFHI  = 4'd0;
  localparam logic [3:0] OP_MFLO  = 4'd1;
  localparam logic [3:0] OP_MTHI  = 4'd2;
  localparam logic [3:0] OP_MTLO  = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_DIVU  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DIV_FIX} state_e;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_e;

  state_e            state, state_nxt;
  acc_e              acc_mode;
  logic [DATA_W-1:0] hi, lo, hi_nxt, lo_nxt;
  logic              hi_we, lo_we;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  cnt;

  logic [3:0]        op;
  logic [DATA_W-1:0] rs, rt;
  logic              accept, busy;
  logic              is_mul, is_div, mul_signed;

  logic [PW-1:0]     ext_a, ext_b, prod_in, pipe_out, acc_res;
  logic [PW-1:0]     pipe [MUL_STAGES];
  logic              pipe_en;

  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic [DATA_W-1:0] rem, quo, dvs;
  logic              q_neg, r_neg;
  logic [DATA_W:0]   trial;

  assign op     = mdu.mul__opcode_2a;
  assign rs     = mdu.rs_data_2a;
  assign rt     = mdu.rt_data_2a;
  assign busy   = (state != IDLE);
  assign accept = mdu.mul__active_2a && !busy && !mdu.mul__flush;

  assign mdu.mul__busy       = busy;
  assign mdu.mul__stall_2a   = mdu.mul__active_2a && busy;
  assign mdu.mul__rd_data_3a = rd_data;

  assign is_mul     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                      (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);

  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign ext_a   = mul_signed ? {{DATA_W{rs[DATA_W-1]}}, rs} : {{DATA_W{1'b0}}, rs};
  assign ext_b   = mul_signed ? {{DATA_W{rt[DATA_W-1]}}, rt} : {{DATA_W{1'b0}}, rt};
  assign prod_in = ext_a * ext_b;

  // Product delay line; retiming spreads the multiplier across these stages.
  assign pipe_en  = (accept && is_mul) || (state == MUL_RUN);
  assign pipe_out = pipe[MUL_STAGES-1];

  always_ff @(posedge clk) begin
    if (pipe_en) begin
      pipe[0] <= prod_in;
      for (int i = 1; i < MUL_STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    acc_res = pipe_out;
    case (acc_mode)
      ACC_ADD: acc_res = {hi, lo} + pipe_out;
      ACC_SUB: acc_res = {hi, lo} - pipe_out;
      default: acc_res = pipe_out;
    endcase
  end

  assign rs_neg = (op == OP_DIV) && rs[DATA_W-1];
  assign rt_neg = (op == OP_DIV) && rt[DATA_W-1];
  assign rs_mag = rs_neg ? (DATA_W'(0) - rs) : rs;
  assign rt_mag = rt_neg ? (DATA_W'(0) - rt) : rt;

  // rem < dvs always holds, so the top bit of trial is a clean borrow flag.
  assign trial = {rem, quo[DATA_W-1]} - {1'b0, dvs};

  always_comb begin
    state_nxt = state;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_nxt = MUL_RUN;
          end else if (is_div) begin
            state_nxt = (rt == '0) ? DIV_FIX : DIV_RUN;
          end else if (op == OP_MTHI) begin
            hi_we  = 1'b1;
            hi_nxt = rs;
          end else if (op == OP_MTLO) begin
            lo_we  = 1'b1;
            lo_nxt = rs;
          end
        end
      end
      MUL_RUN: begin
        if (cnt == CNT_W'(MUL_STAGES - 1)) begin
          state_nxt        = IDLE;
          hi_we            = 1'b1;
          lo_we            = 1'b1;
          {hi_nxt, lo_nxt} = acc_res;
        end
      end
      DIV_RUN: begin
        if (cnt == CNT_W'(DATA_W - 1)) begin
          state_nxt = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_nxt = IDLE;
        hi_we     = 1'b1;
        lo_we     = 1'b1;
        hi_nxt    = r_neg ? (DATA_W'(0) - rem) : rem;
        lo_nxt    = q_neg ? (DATA_W'(0) - quo) : quo;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush beats completion: nothing in flight may reach hi/lo.
    if (mdu.mul__flush) begin
      state_nxt = IDLE;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= IDLE;
      acc_mode <= ACC_NONE;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hi_we) hi <= hi_nxt;
      if (lo_we) lo <= lo_nxt;

      rd_data <= '0;
      if (accept && op == OP_MFHI) rd_data <= hi;
      else if (accept && op == OP_MFLO) rd_data <= lo;

      if (accept) cnt <= '0;
      else if (state == MUL_RUN || state == DIV_RUN) cnt <= cnt + CNT_W'(1);

      if (accept && is_mul) begin
        if (op == OP_MADD || op == OP_MADDU) acc_mode <= ACC_ADD;
        else if (op == OP_MSUB || op == OP_MSUBU) acc_mode <= ACC_SUB;
        else acc_mode <= ACC_NONE;
      end

      if (accept && is_div) begin
        if (rt == '0) begin
          // Early-out: DIV_FIX writes hi=rs, lo=all-ones unmodified.
          rem   <= rs;
          quo   <= '1;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end else begin
          rem   <= '0;
          quo   <= rs_mag;
          dvs   <= rt_mag;
          q_neg <= rs_neg ^ rt_neg;
          r_neg <= rs_neg;
        end
      end else if (state == DIV_RUN) begin
        if (!trial[DATA_W]) begin
          rem <= trial[DATA_W-1:0];
          quo <= {quo[DATA_W-2:0], 1'b1};
        end else begin
          rem <= {rem[DATA_W-2:0], quo[DATA_W-1]};
          quo <= {quo[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit/4-stage and 16-bit/1-stage instances sharing clock and reset.
module tb_muldiv_unit;

  localparam logic [3:0] OP_MFHI  = 4'd0;
  localparam logic [3:0] OP_MFLO  = 4'd1;
  localparam logic [3:0] OP_MTHI  = 4'd2;
  localparam logic [3:0] OP_MTLO  = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_DIV   = 4'd6;
  localparam logic [3:0] OP_DIVU  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.DATA_W(32)) b32 ();
  muldiv_unit_if #(.DATA_W(16)) b16 ();

  muldiv_unit #(.DATA_W(32), .MUL_STAGES(4)) dut32 (.clk(clk), .rst_b(rst_b), .mdu(b32.slave));
  muldiv_unit #(.DATA_W(16), .MUL_STAGES(1)) dut16 (.clk(clk), .rst_b(rst_b), .mdu(b16.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    b32.mul__active_2a = 1'b1;
    b32.mul__opcode_2a = op;
    b32.rs_data_2a     = a;
    b32.rt_data_2a     = b;
    step();
    b32.mul__active_2a = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    b16.mul__active_2a = 1'b1;
    b16.mul__opcode_2a = op;
    b16.rs_data_2a     = a;
    b16.rt_data_2a     = b;
    step();
    b16.mul__active_2a = 1'b0;
  endtask

  // Counts cycles busy is seen high after an issue; bounded so a stuck unit still ends.
  task automatic wait32(output int n);
    n = 0;
    while (b32.mul__busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic wait16(output int n);
    n = 0;
    while (b16.mul__busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic read32(input logic [3:0] op, output logic [31:0] v);
    issue32(op, 32'h0, 32'h0);
    v = b32.mul__rd_data_3a;
  endtask

  task automatic read16(input logic [3:0] op, output logic [15:0] v);
    issue16(op, 16'h0, 16'h0);
    v = b16.mul__rd_data_3a;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    b32.mul__active_2a = 1'b1;
    b32.mul__opcode_2a = OP_MFHI;
    step();
    step();
    checks++; if (b32.mul__rd_data_3a !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", b32.mul__rd_data_3a); end
    checks++; if (b32.mul__busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", b32.mul__busy); end
    checks++; if (b32.mul__stall_2a !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", b32.mul__stall_2a); end
    b32.mul__active_2a = 1'b0;
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_reset_values();
    logic [31:0] v;
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", v); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", v); end
  endtask

  task automatic test_mult();
    logic [31:0] v;
    int n;
    issue32(OP_MULT, 32'hFFFFFFFE, 32'd3);
    checks++; if (b32.mul__busy !== 1'b1) begin failures++; $display("FAIL mult_busy got=%b exp=1", b32.mul__busy); end
    b32.mul__active_2a = 1'b1;
    b32.mul__opcode_2a = OP_MFHI;
    n = 0;
    while (b32.mul__stall_2a && n < 50) begin
      step();
      n++;
    end
    checks++; if (n != 4) begin failures++; $display("FAIL mfhi_stall_cycles got=%0d exp=4", n); end
    step();
    b32.mul__active_2a = 1'b0;
    checks++; if (b32.mul__rd_data_3a !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", b32.mul__rd_data_3a); end
    step();
    checks++; if (b32.mul__rd_data_3a !== 32'h0) begin failures++; $display("FAIL rd_clear got=%h exp=0", b32.mul__rd_data_3a); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffa", v); end
  endtask

  task automatic test_multu();
    logic [31:0] v;
    int n;
    issue32(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    wait32(n);
    checks++; if (n != 4) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=4", n); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL multu_hi got=%h exp=2", v); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffa", v); end
  endtask

  task automatic test_accumulate();
    logic [31:0] v;
    int n;
    issue32(OP_MTHI, 32'h0, 32'h0);
    checks++; if (b32.mul__busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b exp=0", b32.mul__busy); end
    issue32(OP_MTLO, 32'd10, 32'h0);
    issue32(OP_MADD, 32'd3, 32'd4);
    wait32(n);
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL madd_hi got=%h exp=0", v); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h16) begin failures++; $display("FAIL madd_lo got=%h exp=16", v); end
    issue32(OP_MSUBU, 32'd5, 32'd5);
    wait32(n);
    read32(OP_MFHI, v);
    checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL msubu_hi got=%h exp=ffffffff", v); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL msubu_lo got=%h exp=fffffffd", v); end
  endtask

  task automatic test_divide();
    logic [31:0] v;
    int n;
    issue32(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait32(n);
    checks++; if (n != 33) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=33", n); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", v); end
    issue32(OP_DIVU, 32'd7, 32'd0);
    wait32(n);
    checks++; if (n != 1) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=1", n); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h7) begin failures++; $display("FAIL div0_hi got=%h exp=7", v); end
    issue32(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait32(n);
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h80000000) begin failures++; $display("FAIL divmin_lo got=%h exp=80000000", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL divmin_hi got=%h exp=0", v); end
    issue32(OP_DIV, 32'd7, 32'hFFFFFFFE);
    wait32(n);
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_negdvs_lo got=%h exp=fffffffd", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL div_negdvs_hi got=%h exp=1", v); end
    issue32(OP_DIVU, 32'd100, 32'd7);
    wait32(n);
    read32(OP_MFLO, v);
    checks++; if (v !== 32'hE) begin failures++; $display("FAIL divu_lo got=%h exp=e", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h2) begin failures++; $display("FAIL divu_hi got=%h exp=2", v); end
  endtask

  task automatic test_flush();
    logic [31:0] v;
    issue32(OP_MTHI, 32'h11, 32'h0);
    issue32(OP_MTLO, 32'h22, 32'h0);
    issue32(OP_DIV, 32'd100, 32'd3);
    repeat (4) step();
    b32.mul__flush     = 1'b1;
    b32.mul__active_2a = 1'b1;
    b32.mul__opcode_2a = OP_MTLO;
    b32.rs_data_2a     = 32'h99;
    step();
    b32.mul__flush     = 1'b0;
    b32.mul__active_2a = 1'b0;
    checks++; if (b32.mul__busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", b32.mul__busy); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h22) begin failures++; $display("FAIL flush_lo got=%h exp=22", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h11) begin failures++; $display("FAIL flush_hi got=%h exp=11", v); end
    issue32(OP_DIV, 32'd100, 32'd3);
    repeat (32) step();
    checks++; if (b32.mul__busy !== 1'b1) begin failures++; $display("FAIL flush_end_busy_before got=%b exp=1", b32.mul__busy); end
    b32.mul__flush = 1'b1;
    step();
    b32.mul__flush = 1'b0;
    checks++; if (b32.mul__busy !== 1'b0) begin failures++; $display("FAIL flush_end_busy got=%b exp=0", b32.mul__busy); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h22) begin failures++; $display("FAIL flush_end_lo got=%h exp=22", v); end
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h11) begin failures++; $display("FAIL flush_end_hi got=%h exp=11", v); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] v;
    issue32(OP_MTHI, 32'h5, 32'h0);
    issue32(OP_MTLO, 32'h6, 32'h0);
    issue32(OP_MADD, 32'd3, 32'd4);
    step();
    rst_b = 1'b0;
    b32.mul__active_2a = 1'b1;
    b32.mul__opcode_2a = OP_MFLO;
    step();
    checks++; if (b32.mul__stall_2a !== 1'b0) begin failures++; $display("FAIL rstmid_stall got=%b exp=0", b32.mul__stall_2a); end
    checks++; if (b32.mul__busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", b32.mul__busy); end
    checks++; if (b32.mul__rd_data_3a !== 32'h0) begin failures++; $display("FAIL rstmid_rd got=%h exp=0", b32.mul__rd_data_3a); end
    b32.mul__active_2a = 1'b0;
    rst_b = 1'b1;
    repeat (6) step();
    read32(OP_MFHI, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", v); end
    read32(OP_MFLO, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", v); end
  endtask

  task automatic test_w16();
    logic [15:0] v;
    int n;
    issue16(OP_MULT, 16'hFFFE, 16'd3);
    wait16(n);
    checks++; if (n != 1) begin failures++; $display("FAIL w16_mult_busy got=%0d exp=1", n); end
    read16(OP_MFHI, v);
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL w16_mult_hi got=%h exp=ffff", v); end
    read16(OP_MFLO, v);
    checks++; if (v !== 16'hFFFA) begin failures++; $display("FAIL w16_mult_lo got=%h exp=fffa", v); end
    issue16(OP_MULTU, 16'hFFFE, 16'd3);
    wait16(n);
    read16(OP_MFHI, v);
    checks++; if (v !== 16'h2) begin failures++; $display("FAIL w16_multu_hi got=%h exp=2", v); end
    issue16(OP_MTHI, 16'h0, 16'h0);
    issue16(OP_MTLO, 16'd10, 16'h0);
    issue16(OP_MADD, 16'd3, 16'd4);
    wait16(n);
    read16(OP_MFLO, v);
    checks++; if (v !== 16'h16) begin failures++; $display("FAIL w16_madd_lo got=%h exp=16", v); end
    issue16(OP_MSUBU, 16'd5, 16'd5);
    wait16(n);
    read16(OP_MFHI, v);
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL w16_msubu_hi got=%h exp=ffff", v); end
    read16(OP_MFLO, v);
    checks++; if (v !== 16'hFFFD) begin failures++; $display("FAIL w16_msubu_lo got=%h exp=fffd", v); end
    issue16(OP_DIV, 16'hFFF9, 16'd2);
    wait16(n);
    checks++; if (n != 17) begin failures++; $display("FAIL w16_div_busy got=%0d exp=17", n); end
    read16(OP_MFLO, v);
    checks++; if (v !== 16'hFFFD) begin failures++; $display("FAIL w16_div_lo got=%h exp=fffd", v); end
    read16(OP_MFHI, v);
    checks++; if (v !== 16'hFFFF) begin failures++; $display("FAIL w16_div_hi got=%h exp=ffff", v); end
    issue16(OP_DIVU, 16'd7, 16'd0);
    wait16(n);
    checks++; if (n != 1) begin failures++; $display("FAIL w16_div0_busy got=%0d exp=1", n); end
    read16(OP_MFHI, v);
    checks++; if (v !== 16'h7) begin failures++; $display("FAIL w16_div0_hi got=%h exp=7", v); end
    issue16(OP_DIV, 16'h8000, 16'hFFFF);
    wait16(n);
    read16(OP_MFLO, v);
    checks++; if (v !== 16'h8000) begin failures++; $display("FAIL w16_divmin_lo got=%h exp=8000", v); end
    read16(OP_MFHI, v);
    checks++; if (v !== 16'h0) begin failures++; $display("FAIL w16_divmin_hi got=%h exp=0", v); end
  endtask

  initial begin
    b32.mul__active_2a = 1'b0;
    b32.mul__opcode_2a = 4'h0;
    b32.rs_data_2a     = '0;
    b32.rt_data_2a     = '0;
    b32.mul__flush     = 1'b0;
    b16.mul__active_2a = 1'b0;
    b16.mul__opcode_2a = 4'h0;
    b16.rs_data_2a     = '0;
    b16.rt_data_2a     = '0;
    b16.mul__flush     = 1'b0;

    test_reset();
    test_reset_values();
    test_mult();
    test_multu();
    test_accumulate();
    test_divide();
    test_flush();
    test_reset_mid_op();
    test_w16();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
